// File: rtl/mem_stage_v2_pkg.sv
// Shared definitions for the MEM stage: bus field widths, stall polarity,
// one-hot load opcode bit positions, load FSM states and the alignment rule.
package mem_stage_v2_pkg;

  // Fixed-width control fields carried alongside the DATA_W-wide payload
  localparam int PC_W    = 32;
  localparam int OP_W    = 5;
  localparam int WEN_W   = 4;
  localparam int RADDR_W = 5;

  // EX->MEM bus without ex_result: {mem_op, pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr}
  localparam int EX_CTRL_W  = OP_W + PC_W + 1 + WEN_W + 1 + 1 + RADDR_W;
  // MEM->WB bus without rf_wdata: {pc, rf_we, rf_waddr}
  localparam int WB_CTRL_W  = PC_W + 1 + RADDR_W;
  // Forwarding bus without rf_wdata: {rf_we, rf_waddr}
  localparam int FWD_CTRL_W = 1 + RADDR_W;

  // Stall vector polarity
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // One-hot mem_op bit positions, mem_op = {lb, lbu, lh, lhu, lw}
  localparam int OP_LB  = 4;
  localparam int OP_LBU = 3;
  localparam int OP_LH  = 2;
  localparam int OP_LHU = 1;
  localparam int OP_LW  = 0;

  // Load handshake FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } ld_state_e;

  // Halfword loads need an even address, word loads a 4-byte aligned one
  function automatic logic load_misaligned(logic [OP_W-1:0] op, logic [1:0] addr);
    return ((op[OP_LH] | op[OP_LHU]) & addr[0]) |
           (op[OP_LW] & (addr != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_v2_load_align.sv
// Load lane selection and extension. Purely combinational so it can be
// reused in front of a cache read port as well as the raw SRAM port.
module mem_stage_v2_load_align
  import mem_stage_v2_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        addr_i,
  input  logic [OP_W-1:0]   mem_op_i,
  output logic [DATA_W-1:0] data_o,
  output logic              misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel   = rdata_i[{addr_i, 3'b000} +: 8];
  assign half_sel   = rdata_i[{addr_i[1], 4'b0000} +: 16];
  assign misalign_o = load_misaligned(mem_op_i, addr_i);

  // Extend the selected lane according to the one-hot load type
  always_comb begin
    data_o = '0;
    if (mem_op_i[OP_LB]) begin
      data_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
    end else if (mem_op_i[OP_LBU]) begin
      data_o = {{(DATA_W-8){1'b0}}, byte_sel};
    end else if (mem_op_i[OP_LH]) begin
      data_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
    end else if (mem_op_i[OP_LHU]) begin
      data_o = {{(DATA_W-16){1'b0}}, half_sel};
    end else if (mem_op_i[OP_LW]) begin
      data_o = rdata_i;
    end
  end

endmodule

// File: rtl/mem_stage_v2.sv
// MEM pipeline stage: EX->MEM pipeline register, variable-latency load
// handshake with a hold buffer, load alignment, WB bus and ID forwarding.
module mem_stage_v2
  import mem_stage_v2_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int STALL_W = 6,
  parameter int MEM_IDX = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [STALL_W-1:0]               stall,
  input  logic [EX_CTRL_W+DATA_W-1:0]      ex_to_mem_bus,
  input  logic [DATA_W-1:0]                data_sram_rdata,
  input  logic                             data_sram_rvalid,
  output logic [WB_CTRL_W+DATA_W-1:0]      mem_to_wb_bus,
  output logic [FWD_CTRL_W+DATA_W-1:0]     mem_to_id_fwd,
  output logic                             stallreq_mem,
  output logic                             excp_ale
);

  localparam int EX_TO_MEM_WD = EX_CTRL_W + DATA_W;

  logic [EX_TO_MEM_WD-1:0] ex_mem_q, ex_mem_d;
  ld_state_e               state_q;
  logic [DATA_W-1:0]       rbuf_q;

  logic [OP_W-1:0]    mem_op;
  logic [PC_W-1:0]    pc;
  logic               ram_en;
  logic [WEN_W-1:0]   ram_wen;
  logic               sel_rf_res;
  logic               rf_we;
  logic [RADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]  ex_result;

  logic              stage_stop, down_stop, entry_changes;
  logic              is_load, misalign, load_ok, waiting, capture;
  logic [DATA_W-1:0] ld_src, ld_data, rf_wdata;
  logic              rf_we_out;
  logic              stall_unused;

  assign {mem_op, pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result} = ex_mem_q;

  // Only this stage's bit and the downstream bit matter here
  assign stall_unused = ^stall;
  assign stage_stop   = (stall[MEM_IDX]   == Stop);
  assign down_stop    = (stall[MEM_IDX+1] == Stop);
  // The register takes a new entry or a bubble whenever it is not holding
  assign entry_changes = !stage_stop || !down_stop;

  // Next pipeline register value: load, insert bubble, or hold
  always_comb begin
    ex_mem_d = ex_mem_q;
    if (!stage_stop) begin
      ex_mem_d = ex_to_mem_bus;
    end else if (!down_stop) begin
      ex_mem_d = '0;
    end
  end

  // EX->MEM pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_mem_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
    end
  end

  // Misaligned loads never start an SRAM handshake
  assign is_load  = ram_en && (ram_wen == '0);
  assign load_ok  = is_load && !misalign;
  assign waiting  = (state_q == ST_IDLE) || (state_q == ST_WAIT);
  assign capture  = load_ok && waiting && data_sram_rvalid;

  assign stallreq_mem = load_ok && waiting && !data_sram_rvalid;
  assign excp_ale     = is_load && misalign;

  // Once DONE, rvalid is stale and the buffered word is authoritative
  assign ld_src = (data_sram_rvalid && waiting) ? data_sram_rdata : rbuf_q;

  mem_stage_v2_load_align #(
    .DATA_W(DATA_W)
  ) u_load_align (
    .rdata_i   (ld_src),
    .addr_i    (ex_result[1:0]),
    .mem_op_i  (mem_op),
    .data_o    (ld_data),
    .misalign_o(misalign)
  );

  // Load handshake FSM and read-data hold buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rbuf_q  <= '0;
    end else begin
      if (capture) begin
        rbuf_q <= data_sram_rdata;
      end
      if (entry_changes) begin
        // The current access leaves the stage; the next entry starts fresh
        state_q <= ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (load_ok) begin
              state_q <= data_sram_rvalid ? ST_DONE : ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (data_sram_rvalid) begin
              state_q <= ST_DONE;
            end
          end
          ST_DONE: begin
            state_q <= ST_DONE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // No register write while data is outstanding or the access faulted
  assign rf_we_out = rf_we && !excp_ale && !stallreq_mem;
  assign rf_wdata  = sel_rf_res ? ld_data : ex_result;

  assign mem_to_wb_bus = {pc, rf_we_out, rf_waddr, rf_wdata};
  assign mem_to_id_fwd = {rf_we_out, rf_waddr, rf_wdata};

endmodule
